// File: rtl/multicycle_control_if.sv
// Control-side bundle between the multicycle FSM and the datapath/memory.
// The controller consumes run/op/mem_ready and drives every strobe and status output.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       op;
    logic             mem_ready;
    logic             mem_req;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCSource;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUctr;
    logic             RegDst;
    logic             RegWrite;
    logic             MemtoReg;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport master (
        output run, op, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUSrcA, ALUSrcB, ALUctr, RegDst, RegWrite, MemtoReg,
               illegal, retire, instr_count, state_dbg
    );

    modport slave (
        input  run, op, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUSrcA, ALUSrcB, ALUctr, RegDst, RegWrite, MemtoReg,
               illegal, retire, instr_count, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback
// sequencing with a ready/request memory stall and a retired-instruction counter.
module multicycle_control #(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_LUI   = 6'b001111
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        LUI_EXEC = 4'd9,
        LUI_WB   = 4'd10
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctr;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
        logic       retire;
    } ctl_t;

    state_t           state, state_nxt;
    ctl_t             ctl, ctl_q;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              count <= '0;
        else if (ctl_q.retire) count <= count + CNT_W'(1);
    end

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        case (state)
            FETCH: begin
                if (bus.run) begin
                    ctl.mem_req   = 1'b1;
                    ctl.mem_read  = 1'b1;
                    ctl.alu_src_b = 2'b01;
                    // IR/PC load only on the completing beat so a stall never double-bumps PC
                    if (bus.mem_ready) begin
                        ctl.ir_write = 1'b1;
                        ctl.pc_write = 1'b1;
                        state_nxt    = DECODE;
                    end
                end
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;
                if (bus.op == OP_LW || bus.op == OP_SW) state_nxt = MEM_ADDR;
                else if (bus.op == OP_RTYPE)            state_nxt = R_EXEC;
                else if (bus.op == OP_BEQ)              state_nxt = BRANCH;
                else if (bus.op == OP_LUI)              state_nxt = LUI_EXEC;
                else begin
                    ctl.illegal = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_nxt     = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ctl.mem_req  = 1'b1;
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (bus.mem_ready) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
                state_nxt      = FETCH;
            end
            MEM_WR: begin
                ctl.mem_req   = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctl.retire = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_ctr   = 2'b10;
                state_nxt     = R_WB;
            end
            R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                ctl.retire    = 1'b1;
                state_nxt     = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_ctr       = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 1'b1;
                ctl.retire        = 1'b1;
                state_nxt         = FETCH;
            end
            LUI_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctr   = 2'b11;
                state_nxt     = LUI_WB;
            end
            LUI_WB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_nxt     = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Reset masks the combinational decode so no strobe survives the rising edge of rst
    assign ctl_q = rst ? '0 : ctl;

    assign bus.mem_req     = ctl_q.mem_req;
    assign bus.MemRead     = ctl_q.mem_read;
    assign bus.MemWrite    = ctl_q.mem_write;
    assign bus.IorD        = ctl_q.iord;
    assign bus.IRWrite     = ctl_q.ir_write;
    assign bus.PCWrite     = ctl_q.pc_write;
    assign bus.PCWriteCond = ctl_q.pc_write_cond;
    assign bus.PCSource    = ctl_q.pc_source;
    assign bus.ALUSrcA     = ctl_q.alu_src_a;
    assign bus.ALUSrcB     = ctl_q.alu_src_b;
    assign bus.ALUctr      = ctl_q.alu_ctr;
    assign bus.RegDst      = ctl_q.reg_dst;
    assign bus.RegWrite    = ctl_q.reg_write;
    assign bus.MemtoReg    = ctl_q.mem_to_reg;
    assign bus.illegal     = ctl_q.illegal;
    assign bus.retire      = ctl_q.retire;
    assign bus.instr_count = count;
    assign bus.state_dbg   = state;

endmodule
